// File: rtl/i2s_tdm_engine.sv
// i2s_tdm_engine: master-mode I2S/TDM full-duplex serial engine.
// NCH slots of DW bits per frame, Tx/Rx FIFOs of DEPTH words, sclk/ws from a pclk divider.
// Optional feature macro: I2S_TDM_LOOPBACK_EN (adds lpbk port; Rx samples sd_o when lpbk=1).

// Synchronous FIFO; a write is accepted when full if a read happens in the same cycle.
module i2s_tdm_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_rd;
  logic          w_do_wr;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rptr];
  assign w_do_rd = i_rd && !o_empty;
  assign w_do_wr = i_wr && (!o_full || w_do_rd);

  // Storage write
  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module i2s_tdm_engine #(
  parameter int unsigned DW    = 32,
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DIVW  = 8
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    en,
  input  logic [DIVW-1:0]         div,
  input  logic                    i2s_dly,
  input  logic                    frame_mode,
  input  logic [DW-1:0]           tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [DW-1:0]           rx_data,
  output logic [$clog2(NCH)-1:0]  rx_chan,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  input  logic                    clr_flags,
  output logic                    tx_underrun,
  output logic                    rx_overrun,
  output logic                    busy,
  output logic                    sclk_o,
  output logic                    ws_o,
  output logic                    sd_o,
  input  logic                    sd_i
`ifdef I2S_TDM_LOOPBACK_EN
  ,
  input  logic                    lpbk
`endif
);
  localparam int unsigned BW = $clog2(DW);
  localparam int unsigned CW = $clog2(NCH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DW - 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(NCH - 1);
  localparam logic [CW-1:0] HALF_SLOT = CW'(NCH / 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [DIVW-1:0] r_div, r_divcnt;
  logic            r_dly, r_fm, r_sclk;
  logic [BW-1:0]   r_bit, w_nbit;
  logic [CW-1:0]   r_slot, w_nslot, r_rx_pchan;
  logic [DW-1:0]   r_txsh, r_rxsh, w_tx_head;
  logic            r_rx_pend, r_underrun, r_overrun;
  logic            w_busy, w_tc, w_rise, w_fall, w_last_bit, w_last_slot;
  logic            w_frame_end, w_start, w_stop, w_load, w_sdin;
  logic            w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;

  assign w_busy      = (r_state != S_IDLE);
  assign w_tc        = w_busy && (r_divcnt == r_div);
  assign w_rise      = w_tc && !r_sclk;
  assign w_fall      = w_tc && r_sclk;
  assign w_last_bit  = (r_bit == LAST_BIT);
  assign w_last_slot = (r_slot == LAST_SLOT);
  assign w_frame_end = w_fall && w_last_bit && w_last_slot;
  assign w_start     = (r_state == S_IDLE) && en;
  assign w_stop      = (r_state == S_DRAIN) && w_frame_end;
  assign w_load      = w_start || (w_fall && w_last_bit && !w_stop);

`ifdef I2S_TDM_LOOPBACK_EN
  assign w_sdin = lpbk ? sd_o : sd_i;
`else
  assign w_sdin = sd_i;
`endif

  i2s_tdm_fifo #(.W(DW), .DEPTH(DEPTH)) u_tx_fifo (
    .i_clk(pclk), .i_rst_n(preset), .i_wr(tx_valid && !w_tx_full), .i_wdata(tx_data),
    .i_rd(w_load), .o_rdata(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  i2s_tdm_fifo #(.W(DW + CW), .DEPTH(DEPTH)) u_rx_fifo (
    .i_clk(pclk), .i_rst_n(preset), .i_wr(r_rx_pend), .i_wdata({r_rxsh, r_rx_pchan}),
    .i_rd(rx_ready), .o_rdata({rx_data, rx_chan}), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  // FSM state register
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: drain always finishes the frame before going idle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en)          w_state_nxt = S_RUN;
      S_RUN:   if (!en)         w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_frame_end) w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // Divider, bit/slot counters and Tx shifter
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_div    <= '0;
      r_dly    <= 1'b0;
      r_fm     <= 1'b0;
      r_divcnt <= '0;
      r_sclk   <= 1'b0;
      r_bit    <= '0;
      r_slot   <= '0;
      r_txsh   <= '0;
    end else if (w_start) begin
      r_div    <= div;
      r_dly    <= i2s_dly;
      r_fm     <= frame_mode;
      r_divcnt <= '0;
      r_sclk   <= 1'b0;
      r_bit    <= '0;
      r_slot   <= '0;
      r_txsh   <= w_tx_empty ? '0 : w_tx_head;
    end else if (w_stop) begin
      r_divcnt <= '0;
      r_sclk   <= 1'b0;
      r_bit    <= '0;
      r_slot   <= '0;
      r_txsh   <= '0;
    end else if (w_busy) begin
      if (w_tc) begin
        r_divcnt <= '0;
        r_sclk   <= ~r_sclk;
      end else begin
        r_divcnt <= r_divcnt + 1'b1;
      end
      if (w_fall) begin
        if (w_last_bit) begin
          r_bit  <= '0;
          r_slot <= w_last_slot ? '0 : r_slot + 1'b1;
          r_txsh <= w_tx_empty ? '0 : w_tx_head;
        end else begin
          r_bit  <= r_bit + 1'b1;
          r_txsh <= {r_txsh[DW-2:0], 1'b0};
        end
      end
    end
  end

  // Rx shifter; full word is queued for push the cycle after its last bit is sampled
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_rxsh     <= '0;
      r_rx_pend  <= 1'b0;
      r_rx_pchan <= '0;
    end else begin
      r_rx_pend <= w_rise && w_last_bit;
      if (w_rise) begin
        r_rxsh     <= {r_rxsh[DW-2:0], w_sdin};
        r_rx_pchan <= r_slot;
      end
    end
  end

  // Sticky error flags; a set in the same cycle wins over clear
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_load && w_tx_empty) r_underrun <= 1'b1;
      else if (clr_flags)       r_underrun <= 1'b0;
      if (r_rx_pend && w_rx_full && !rx_ready) r_overrun <= 1'b1;
      else if (clr_flags)                      r_overrun <= 1'b0;
    end
  end

  // ws position: one bit ahead of the data counters when the I2S delay is on
  always_comb begin
    w_nbit  = r_bit;
    w_nslot = r_slot;
    if (r_dly) begin
      if (w_last_bit) begin
        w_nbit  = '0;
        w_nslot = w_last_slot ? '0 : r_slot + 1'b1;
      end else begin
        w_nbit = r_bit + 1'b1;
      end
    end
  end

  assign ws_o        = w_busy && (r_fm ? ((w_nslot == '0) && (w_nbit == '0)) : (w_nslot >= HALF_SLOT));
  assign sclk_o      = r_sclk;
  assign sd_o        = r_txsh[DW-1];
  assign busy        = w_busy;
  assign tx_ready    = !w_tx_full;
  assign rx_valid    = !w_rx_empty;
  assign tx_underrun = r_underrun;
  assign rx_overrun  = r_overrun;
endmodule
